// File: rtl/seq_restoring_div32_if.sv
// Valid/ready bundle for seq_restoring_div32: operand request side and result side.
// The div_zero signal exists only when DIV_ZERO_FAST_EN is defined.
interface seq_restoring_div32_if #(
  parameter int unsigned NUM_W = 32,
  parameter int unsigned DEN_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [NUM_W-1:0] dividend;
  logic [DEN_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [NUM_W-1:0] quotient;
  logic [DEN_W-1:0] remainder;
`ifdef DIV_ZERO_FAST_EN
  logic             div_zero;
`endif

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
`ifdef DIV_ZERO_FAST_EN
    input  div_zero,
`endif
    input  remainder
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
`ifdef DIV_ZERO_FAST_EN
    output div_zero,
`endif
    output remainder
  );
endinterface

// File: rtl/seq_restoring_div32.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_FAST_EN: divisor 0 short-circuits to DONE and raises div_zero.
module seq_restoring_div32 #(
  parameter int unsigned NUM_W = 32,
  parameter int unsigned DEN_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_restoring_div32_if.slave bus
);

  localparam int unsigned CntW = $clog2(NUM_W);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [NUM_W-1:0] quo_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic             in_ready_q;
  logic             out_valid_q;
`ifdef DIV_ZERO_FAST_EN
  logic             div_zero_q;
`endif

  // The DEN_W+1-bit partial remainder only exists as the shifted value; the stored
  // remainder is always below the divisor so DEN_W bits suffice.
  logic [DEN_W:0]   shifted;
  logic [DEN_W+1:0] trial;
  logic             borrow;
  logic             unused_trial_bit;

  always_comb begin
    shifted          = {rem_q, quo_q[NUM_W-1]};
    trial            = {1'b0, shifted} - {2'b00, den_q};
    borrow           = trial[DEN_W+1];
    unused_trial_bit = trial[DEN_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            den_q      <= bus.divisor;
            in_ready_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            if (bus.divisor == '0) begin
              quo_q       <= '1;
              rem_q       <= bus.dividend[DEN_W-1:0];
              out_valid_q <= 1'b1;
              div_zero_q  <= 1'b1;
              state_q     <= StDone;
            end else begin
              quo_q   <= bus.dividend;
              rem_q   <= '0;
              cnt_q   <= CntW'(NUM_W - 1);
              state_q <= StBusy;
            end
`else
            quo_q   <= bus.dividend;
            rem_q   <= '0;
            cnt_q   <= CntW'(NUM_W - 1);
            state_q <= StBusy;
`endif
          end
        end
        StBusy: begin
          quo_q <= {quo_q[NUM_W-2:0], ~borrow};
          rem_q <= borrow ? shifted[DEN_W-1:0] : trial[DEN_W-1:0];
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
            div_zero_q  <= 1'b0;
`endif
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef DIV_ZERO_FAST_EN
  assign bus.div_zero  = div_zero_q;
`endif

endmodule
